// File: rtl/n_twisted_ring_counter.sv
// n_twisted_ring_counter
//
// Parameterised twisted-ring (Johnson) counter built from NUMBER_OF_FLOPS
// D flip-flops. The chain shifts toward the MSB and the inverted MSB is fed
// back into bit 0. From the all-zero reset state it walks a 2*N-state
// sequence, so q_out toggles every N cycles: a divide-by-2N square wave
// with a 50 % duty cycle. When N is 1 the chain reduces to a single flop
// that toggles on every edge (divide-by-2).
//
// Only the 2N Johnson codes are reachable from reset. There is no
// self-correction for illegal codes; reset is the recovery path.
//
// Parameters
//   NUMBER_OF_FLOPS  chain length N, legal range 1..64 (default 3)
//
// Ports
//   clk    in   1  clock, state updates on the rising edge
//   rst    in   1  synchronous reset, active-low (0 = clear the chain)
//   q_out  out  1  MSB of the chain, driven straight from its flop

module n_twisted_ring_counter #(
  parameter int NUMBER_OF_FLOPS = 3
) (
  input  logic clk,
  input  logic rst,
  output logic q_out
);

  localparam int N = NUMBER_OF_FLOPS;

  // A chain of zero flops has no meaning; stop elaboration outright.
  generate
    if (N < 1) begin : g_bad_length
      $error("n_twisted_ring_counter: NUMBER_OF_FLOPS must be >= 1");
    end
  endgenerate

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  // Bit 0 takes the inverted MSB. For N == 1 this is the same flop, so
  // the chain collapses into a toggle without a separate code path.
  assign q_d[0] = ~q_q[N-1];

  // Every other bit takes its lower neighbour (shift toward the MSB).
  generate
    for (genvar gi = 1; gi < N; gi++) begin : g_shift
      assign q_d[gi] = q_q[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_out = q_q[N-1];

endmodule

// File: tb/tb_n_twisted_ring_counter.sv
// Self-checking bench for n_twisted_ring_counter.
// Four instances (N = 1, 3, 4, 5) run side by side, each with its own
// randomly pulsed active-low reset. The reference model only counts active
// edges since the last reset: the state index is that count modulo 2N,
// q_out is high for indices N..2N-1, and the Johnson code for an index is
// derived arithmetically. The N = 5 instance also has its full internal
// state compared against that code, so every value it takes must be one
// of the 10 legal Johnson codes.

module tb_n_twisted_ring_counter;

  localparam int NUM_INST = 4;
  localparam int NUM_ITER = 3000;

  logic clk;
  logic [NUM_INST-1:0] rst;
  logic [NUM_INST-1:0] q_out;

  int vectors;
  int miscompares;

  // Chain lengths for the instances, in the same order as rst/q_out bits.
  int n_of [NUM_INST];
  // Active edges seen since the last reset edge, per instance.
  int edge_cnt [NUM_INST];

  initial begin
    clk = 1'b0;
    forever #2 clk = ~clk;
  end

  n_twisted_ring_counter #(.NUMBER_OF_FLOPS(1)) u_n1 (.clk(clk), .rst(rst[0]), .q_out(q_out[0]));
  n_twisted_ring_counter #(.NUMBER_OF_FLOPS(3)) u_n3 (.clk(clk), .rst(rst[1]), .q_out(q_out[1]));
  n_twisted_ring_counter #(.NUMBER_OF_FLOPS(4)) u_n4 (.clk(clk), .rst(rst[2]), .q_out(q_out[2]));
  n_twisted_ring_counter #(.NUMBER_OF_FLOPS(5)) u_n5 (.clk(clk), .rst(rst[3]), .q_out(q_out[3]));

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Johnson code at sequence index idx (0 .. 2n-1) for an n-flop ring:
  // the first n steps fill with ones from the LSB, the next n steps
  // clear them again from the LSB.
  function automatic logic [63:0] johnson_code(input int n, input int idx);
    logic [63:0] ones;
    logic [63:0] mask;
    ones = 64'd1;
    mask = (ones << n) - 64'd1;
    if (idx <= n) begin
      return (ones << idx) - 64'd1;
    end
    return mask & ~((ones << (idx - n)) - 64'd1);
  endfunction

  // Advance the model for one active edge, using the reset value applied.
  task automatic model_edge();
    for (int i = 0; i < NUM_INST; i++) begin
      if (!rst[i]) edge_cnt[i] = 0;
      else         edge_cnt[i] = (edge_cnt[i] + 1) % (2 * n_of[i]);
    end
  endtask

  task automatic check_all(input int cyc);
    string tag;
    for (int i = 0; i < NUM_INST; i++) begin
      tag = $sformatf("q_out_n%0d_c%0d", n_of[i], cyc);
      check_eq(tag, {63'd0, q_out[i]}, {63'd0, (edge_cnt[i] >= n_of[i])});
    end
    tag = $sformatf("state_n5_c%0d", cyc);
    check_eq(tag, {59'd0, u_n5.q_q}, johnson_code(5, edge_cnt[3]));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    n_of[0] = 1; n_of[1] = 3; n_of[2] = 4; n_of[3] = 5;
    for (int i = 0; i < NUM_INST; i++) edge_cnt[i] = 0;

    // Hold every instance in reset for several edges; q_out must read 0.
    rst = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(c);
      $display("cycle %0d rst=%b q_out=%b (reset hold)", c, rst, q_out);
    end

    // Release and run with occasional random mid-count resets.
    rst = '1;
    for (int c = 3; c < NUM_ITER; c++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(c);
      $display("cycle %0d rst=%b q_out=%b", c, rst, q_out);
      for (int i = 0; i < NUM_INST; i++) begin
        rst[i] = ($urandom_range(0, 19) != 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
